// File: rtl/deflate_pkg.sv
// Shared types and constants for the fixed-Huffman DEFLATE stream controller.
package deflate_pkg;

  localparam logic [1:0] BTYPE_FIXED = 2'b01;
  localparam logic       BFINAL      = 1'b1;
  localparam int         HDR_BITS    = 3;

  // BFINAL is stream bit 0, then BTYPE LSB-first.
  localparam logic [HDR_BITS-1:0] BLOCK_HDR = {BTYPE_FIXED, BFINAL};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef struct packed {
    logic        last;
    logic [2:0]  bytes;
    logic [31:0] data;
  } word_t;

  function automatic logic [6:0] round_up8(input logic [6:0] n);
    return (n + 7'd7) & 7'h78;
  endfunction

endpackage

// File: rtl/deflate_stream_ctrl_if.sv
// Code-fragment input and packed-word output bus of deflate_stream_ctrl.
interface deflate_stream_ctrl_if #(
  parameter int IN_WIDTH = 32
);
  logic                filt_valid;
  logic [5:0]          filt_size;
  logic [IN_WIDTH-1:0] filt_data;
  logic                filt_last;
  logic                out_ready;
  logic                out_valid;
  logic [31:0]         out_data;
  logic                out_last;
  logic [2:0]          out_bytes;

  modport master (
    output filt_valid, filt_size, filt_data, filt_last, out_ready,
    input  out_valid, out_data, out_last, out_bytes
  );

  modport slave (
    input  filt_valid, filt_size, filt_data, filt_last, out_ready,
    output out_valid, out_data, out_last, out_bytes
  );
endinterface

// File: rtl/deflate_word_fifo.sv
// Show-ahead word FIFO; push and pop on a full FIFO in the same cycle is lossless.
module deflate_word_fifo
  import deflate_pkg::*;
#(
  parameter int DEPTH_LOG = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  word_t wdata,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output word_t rdata
);
  localparam logic [DEPTH_LOG:0] DEPTH = {1'b1, {DEPTH_LOG{1'b0}}};

  word_t                mem [2**DEPTH_LOG];
  logic [DEPTH_LOG-1:0] wptr, rptr;
  logic [DEPTH_LOG:0]   count;
  logic                 do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Outputs read as zero while empty so reset leaves every output low.
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/deflate_stream_ctrl.sv
// Wraps match-filter codes in one fixed-Huffman DEFLATE block and packs them into 32-bit words.
// Optional DEFLATE_BYTE_CNT_EN adds a byte_cnt output counting bytes pushed this block.
module deflate_stream_ctrl
  import deflate_pkg::*;
#(
  parameter int FIFO_DEPTH_LOG = 2,
  parameter int IN_WIDTH       = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  deflate_stream_ctrl_if.slave bus,
  output logic busy,
  output logic done,
  output logic overflow,
  output logic protocol_err
`ifdef DEFLATE_BYTE_CNT_EN
  ,
  output logic [31:0] byte_cnt
`endif
);
  state_t      state, state_nx;
  logic [63:0] acc, acc_nx, acc_app;
  logic [6:0]  cnt, cnt_nx, cnt_app, size_c;
  logic [31:0] frag;
  logic        push, pop, full, empty, accepted;
  word_t       push_word, head;

  // Reverse so filt_data[size-1] lands at the lowest stream position.
  function automatic logic [31:0] fragment(input logic [IN_WIDTH-1:0] d, input logic [6:0] n);
    logic [IN_WIDTH-1:0] r;
    for (int i = 0; i < IN_WIDTH; i++) r[i] = d[IN_WIDTH-1-i];
    r = r >> (7'(IN_WIDTH) - n);
    return 32'(r);
  endfunction

  assign size_c   = ({1'b0, bus.filt_size} > 7'(IN_WIDTH)) ? 7'(IN_WIDTH) : {1'b0, bus.filt_size};
  assign frag     = fragment(bus.filt_data, size_c);
  assign acc_app  = acc | ({32'd0, frag} << cnt);
  assign cnt_app  = cnt + size_c;
  assign pop      = ~empty & bus.out_ready;
  assign accepted = push & (~full | pop);

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    push      = 1'b0;
    push_word = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = STREAM;
          acc_nx   = {{(64-HDR_BITS){1'b0}}, BLOCK_HDR};
          cnt_nx   = 7'(HDR_BITS);
        end
      end
      STREAM: begin
        if (bus.filt_valid) begin
          if (bus.filt_last) begin
            // Padding is already zero: bits above cnt are never set.
            acc_nx   = acc_app;
            cnt_nx   = round_up8(cnt_app);
            state_nx = FLUSH;
          end else if (cnt_app >= 7'd32) begin
            push      = 1'b1;
            push_word = '{last: 1'b0, bytes: 3'd4, data: acc_app[31:0]};
            acc_nx    = acc_app >> 32;
            cnt_nx    = cnt_app - 7'd32;
          end else begin
            acc_nx = acc_app;
            cnt_nx = cnt_app;
          end
        end
      end
      FLUSH: begin
        if (!full) begin
          push = 1'b1;
          if (cnt > 7'd32) begin
            push_word = '{last: 1'b0, bytes: 3'd4, data: acc[31:0]};
            acc_nx    = acc >> 32;
            cnt_nx    = cnt - 7'd32;
          end else begin
            push_word = '{last: 1'b1, bytes: cnt[5:3], data: acc[31:0]};
            acc_nx    = '0;
            cnt_nx    = '0;
            state_nx  = DONE;
          end
        end
      end
      DONE: begin
        if (empty) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        overflow     <= 1'b0;
        protocol_err <= 1'b0;
      end
      if (push && full && !pop)                overflow     <= 1'b1;
      if (bus.filt_valid && state != STREAM)   protocol_err <= 1'b1;
    end
  end

`ifdef DEFLATE_BYTE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (state == IDLE && start) begin
      byte_cnt <= '0;
    end else if (accepted) begin
      byte_cnt <= byte_cnt + {29'd0, push_word.bytes};
    end
  end
`endif

  deflate_word_fifo #(
    .DEPTH_LOG (FIFO_DEPTH_LOG)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .rdata (head)
  );

  assign bus.out_valid = ~empty;
  assign bus.out_data  = head.data;
  assign bus.out_last  = head.last;
  assign bus.out_bytes = head.bytes;
  assign busy          = (state != IDLE);
  assign done          = (state == DONE) && empty;

endmodule

// File: tb/tb_deflate_stream_ctrl.sv
// Bench for deflate_stream_ctrl: bit-queue stream model, directed cases and randomized blocks.
module tb_deflate_stream_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done, overflow, protocol_err;
`ifdef DEFLATE_BYTE_CNT_EN
  logic [31:0] byte_cnt;
`endif

  deflate_stream_ctrl_if #(.IN_WIDTH(32)) bus ();

  deflate_stream_ctrl #(
    .FIFO_DEPTH_LOG (2),
    .IN_WIDTH       (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .protocol_err (protocol_err)
`ifdef DEFLATE_BYTE_CNT_EN
    ,
    .byte_cnt     (byte_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam int CAP = 4;
  typedef enum {M_IDLE, M_STREAM, M_FLUSH, M_DONE} mphase_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  mphase_t     ph;
  bit          bits[$];
  logic [35:0] mfifo[$];
  logic [35:0] flushq[$];
  logic [35:0] dut_log[$];
  logic [35:0] obs;
  bit          m_ovf, m_perr;
  int unsigned m_bytes;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = M_IDLE;
    bits.delete();
    mfifo.delete();
    flushq.delete();
    m_ovf = 1'b0;
    m_perr = 1'b0;
    m_bytes = 0;
  endtask

  function automatic logic [31:0] take32();
    logic [31:0] w = '0;
    for (int k = 0; k < 32; k++)
      if (bits.size() > 0) w[k] = bits.pop_front();
    return w;
  endfunction

  task automatic compare();
    logic [35:0] f;
    obs = {bus.out_last, bus.out_bytes, bus.out_data};
    if (done) done_cnt++;
    chk("out_valid", 64'(bus.out_valid), 64'(mfifo.size() > 0));
    if (mfifo.size() > 0) begin
      f = mfifo[0];
      chk("out_word", 64'(obs), 64'(f));
    end
    chk("busy", 64'(busy), 64'(ph != M_IDLE));
    chk("done", 64'(done), 64'(ph == M_DONE && mfifo.size() == 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("protocol_err", 64'(protocol_err), 64'(m_perr));
`ifdef DEFLATE_BYTE_CNT_EN
    chk("byte_cnt", 64'(byte_cnt), 64'(m_bytes));
`endif
  endtask

  task automatic step(input bit st, input bit fv, input int sz, input logic [31:0] d,
                      input bit lst, input bit rdy);
    bit          pop, full, do_push;
    logic [35:0] w;
    int          r;
    do_push = 1'b0;
    w = '0;
    pop  = rdy && (mfifo.size() > 0);
    full = (mfifo.size() == CAP);
    if (pop) dut_log.push_back(obs);
    case (ph)
      M_IDLE: begin
        if (st) begin
          m_ovf = 1'b0; m_perr = 1'b0; m_bytes = 0;
          bits.delete();
          bits.push_back(1'b1); bits.push_back(1'b1); bits.push_back(1'b0);
          ph = M_STREAM;
        end
        if (fv) m_perr = 1'b1;
      end
      M_STREAM: begin
        if (fv) begin
          for (int i = sz - 1; i >= 0; i--) bits.push_back(d[i]);
          if (lst) begin
            while (bits.size() % 8 != 0) bits.push_back(1'b0);
            flushq.delete();
            while (bits.size() > 32) flushq.push_back({1'b0, 3'd4, take32()});
            r = bits.size();
            flushq.push_back({1'b1, 3'(r / 8), take32()});
            ph = M_FLUSH;
          end else if (bits.size() >= 32) begin
            w = {1'b0, 3'd4, take32()};
            do_push = 1'b1;
          end
        end
      end
      M_FLUSH: begin
        if (fv) m_perr = 1'b1;
        if (!full) begin
          w = flushq.pop_front();
          do_push = 1'b1;
          if (flushq.size() == 0) ph = M_DONE;
        end
      end
      M_DONE: begin
        if (fv) m_perr = 1'b1;
        if (mfifo.size() == 0) ph = M_IDLE;
      end
      default: ph = M_IDLE;
    endcase
    if (pop) void'(mfifo.pop_front());
    if (do_push) begin
      if (mfifo.size() < CAP) begin
        mfifo.push_back(w);
        m_bytes += int'(w[34:32]);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic cyc(input bit st, input bit fv, input int sz, input logic [31:0] d,
                     input bit lst, input bit rdy);
    @(negedge clk);
    compare();
    start          = st;
    bus.filt_valid = fv;
    bus.filt_size  = 6'(sz);
    bus.filt_data  = d;
    bus.filt_last  = lst;
    bus.out_ready  = rdy;
    step(st, fv, sz, d, lst, rdy);
  endtask

  task automatic drain(input int rdy_pct, input int fv_pct);
    int guard = 0;
    while (ph != M_IDLE && guard < 400) begin
      cyc(1'b0, $urandom_range(0, 99) < fv_pct, 5, $urandom, 1'b0,
          $urandom_range(0, 99) < rdy_pct);
      guard++;
    end
    if (guard >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: block still active after %0d cycles, required idle", guard);
    end
    cyc(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int nfr, rpct;
    bit fv, lst;
    bus.filt_valid = 1'b0; bus.filt_size = '0; bus.filt_data = '0;
    bus.filt_last = 1'b0; bus.out_ready = 1'b0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_protocol_err", 64'(protocol_err), 64'd0);
    rst_n = 1'b1;

    // Case 1: header plus a 7-bit zero code.
    dut_log.delete(); done_cnt = 0;
    cyc(1, 0, 0, 32'd0, 0, 1);
    cyc(0, 1, 7, 32'd0, 1, 1);
    drain(100, 0);
    chk("t1_words", 64'(dut_log.size()), 64'd1);
    if (dut_log.size() >= 1) chk("t1_word", 64'(dut_log[0]), {28'd0, 1'b1, 3'd2, 32'h00000003});
    chk("t1_done_pulses", 64'(done_cnt), 64'd1);

    // Case 2: four all-ones 32-bit fragments.
    dut_log.delete();
    cyc(1, 0, 0, 32'd0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32, 32'hFFFFFFFF, i == 3, 1);
    drain(100, 0);
    chk("t2_words", 64'(dut_log.size()), 64'd5);
    if (dut_log.size() == 5) begin
      chk("t2_first", 64'(dut_log[0]), {28'd0, 1'b0, 3'd4, 32'hFFFFFFFB});
      chk("t2_last", 64'(dut_log[4]), {28'd0, 1'b1, 3'd1, 32'h00000007});
    end
`ifdef DEFLATE_BYTE_CNT_EN
    chk("t6_byte_cnt", 64'(byte_cnt), 64'd17);
`endif

    // Case 3: no backpressure relief, FIFO fills and drops.
    dut_log.delete();
    cyc(1, 0, 0, 32'd0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 32, 32'hFFFFFFFF, 0, 0);
    @(posedge clk); #1;
    chk("t3_no_ovf_at_4", 64'(overflow), 64'd0);
    cyc(0, 1, 32, 32'hFFFFFFFF, 0, 0);
    @(posedge clk); #1;
    chk("t3_ovf_at_5", 64'(overflow), 64'd1);
    chk("t3_out_valid", 64'(bus.out_valid), 64'd1);
    cyc(0, 1, 32, 32'hFFFFFFFF, 0, 0);
    cyc(0, 1, 0, 32'd0, 1, 0);
    repeat (3) cyc(0, 0, 0, 32'd0, 0, 0);
    drain(100, 0);
    chk("t3_words", 64'(dut_log.size()), 64'd5);
    if (dut_log.size() == 5) begin
      chk("t3_first", 64'(dut_log[0]), {28'd0, 1'b0, 3'd4, 32'hFFFFFFFB});
      chk("t3_last", 64'(dut_log[4]), {28'd0, 1'b1, 3'd1, 32'h00000007});
    end

    // Case 4: fragment with no block open.
    cyc(0, 1, 5, 32'h1F, 0, 1);
    @(posedge clk); #1;
    chk("t4_protocol_err", 64'(protocol_err), 64'd1);
    chk("t4_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t4_busy", 64'(busy), 64'd0);
    cyc(0, 0, 0, 32'd0, 0, 1);

    // Case 5: asynchronous reset in the middle of a block.
    cyc(1, 0, 0, 32'd0, 0, 0);
    cyc(0, 1, 32, 32'hA5A5A5A5, 0, 0);
    cyc(0, 1, 9, 32'h1FF, 0, 0);
    @(posedge clk); #2;
    start = 1'b0; bus.filt_valid = 1'b0; bus.filt_last = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t5_out_data", 64'(bus.out_data), 64'd0);
    chk("t5_out_last", 64'(bus.out_last), 64'd0);
    chk("t5_out_bytes", 64'(bus.out_bytes), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_overflow", 64'(overflow), 64'd0);
    chk("t5_protocol_err", 64'(protocol_err), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dut_log.delete();
    cyc(1, 0, 0, 32'd0, 0, 1);
    cyc(0, 1, 29, 32'd0, 1, 1);
    drain(100, 0);
    chk("t5_words", 64'(dut_log.size()), 64'd1);
    if (dut_log.size() >= 1) chk("t5_fresh_hdr", 64'(dut_log[0]), {28'd0, 1'b1, 3'd4, 32'h00000003});

    // Randomized blocks.
    for (int blk = 0; blk < 40; blk++) begin
      rpct = (blk % 4 == 0) ? 15 : 80;
      if ($urandom_range(0, 4) == 0) cyc(0, 1, 3, $urandom, 0, 1);
      cyc(1, 0, 0, 32'd0, 0, $urandom_range(0, 99) < rpct);
      nfr = $urandom_range(1, 12);
      for (int f = 0; f < nfr; f++) begin
        lst = (f == nfr - 1);
        fv  = lst || ($urandom_range(0, 3) != 0);
        cyc($urandom_range(0, 7) == 0, fv, $urandom_range(0, 32), $urandom, lst,
            $urandom_range(0, 99) < rpct);
      end
      drain(rpct, 5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
